// File: rtl/modcnt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : modcnt_pkg                                                   |
// | Description : Shared constants, direction type and configuration check    |
// |               for the programmable modulo-N counter.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package modcnt_pkg;

  // Smallest modulus the counter can hold; smaller loads are clamped to this.
  localparam int MODCNT_MIN_MOD   = 2;
  localparam int MODCNT_MIN_WIDTH = 2;
  localparam int MODCNT_MAX_WIDTH = 16;

  // Count direction as seen by the next-count generator.
  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // True when WIDTH and DEFAULT_MOD form a usable configuration.
  function automatic bit modcnt_cfg_ok(input int width, input int default_mod);
    if (width < MODCNT_MIN_WIDTH || width > MODCNT_MAX_WIDTH) begin
      return 1'b0;
    end
    if (default_mod < MODCNT_MIN_MOD) begin
      return 1'b0;
    end
    if (default_mod > ((1 << width) - 1)) begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage : modcnt_pkg
`default_nettype wire

// File: rtl/modcnt_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : modcnt_next                                                  |
// | Description : Combinational next-count and wrap generator for a modulo-N   |
// |               counter. Up: 0..mod-1 then 0. Down: mod-1..0 then mod-1.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module modcnt_next
  import modcnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] mod_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  // mod_i is never below 2, so this subtraction cannot underflow.
  logic [WIDTH-1:0] last_val;
  assign last_val = mod_i - WIDTH'(1);

  // Select the successor value and flag the wrap point for the current direction.
  always_comb begin
    next_o = count_i;
    wrap_o = 1'b0;
    if (dir_i == DIR_UP) begin
      wrap_o = (count_i == last_val);
      next_o = wrap_o ? '0 : (count_i + WIDTH'(1));
    end else begin
      wrap_o = (count_i == '0);
      next_o = wrap_o ? last_val : (count_i - WIDTH'(1));
    end
  end

endmodule : modcnt_next
`default_nettype wire

// File: rtl/prog_modulo_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prog_modulo_counter                                          |
// | Description : Run-time programmable modulo-N counter / clock-enable        |
// |               divider. Counts under en_i, wraps at the modulus, flags the  |
// |               terminal cycle on tc_o and toggles y_o on every wrap.        |
// |               Optional up/down counting via macro MODCNT_UPDOWN_EN, which  |
// |               adds the up_dn_i port (1 = up, 0 = down).                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prog_modulo_counter
  import modcnt_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] mod_in_i,
`ifdef MODCNT_UPDOWN_EN
  input  logic             up_dn_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] mod_o,
  output logic             tc_o,
  output logic             y_o
);

  // Reject unusable parameter sets at elaboration.
  generate
    if (!modcnt_cfg_ok(WIDTH, DEFAULT_MOD)) begin : g_cfg_err
      $fatal(1, "prog_modulo_counter: WIDTH must be 2..16 and DEFAULT_MOD 2..2^WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             y_q, y_d;

  logic             dir;
  logic [WIDTH-1:0] count_next;
  logic             wrap;
  logic [WIDTH-1:0] mod_clamped;

`ifdef MODCNT_UPDOWN_EN
  assign dir = up_dn_i;
`else
  assign dir = DIR_UP;
`endif

  modcnt_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count_i (count_q),
    .mod_i   (mod_q),
    .dir_i   (dir),
    .next_o  (count_next),
    .wrap_o  (wrap)
  );

  // Loaded moduli below the minimum are raised to it so mod_q-1 never underflows.
  assign mod_clamped = (mod_in_i < WIDTH'(MODCNT_MIN_MOD)) ? WIDTH'(MODCNT_MIN_MOD) : mod_in_i;

  // Next-state: load restarts the count without toggling; enable advances and toggles on wrap.
  always_comb begin
    count_d = count_q;
    mod_d   = mod_q;
    y_d     = y_q;
    if (load_i) begin
      mod_d   = mod_clamped;
      count_d = '0;
    end else if (en_i) begin
      count_d = count_next;
      if (wrap) begin
        y_d = ~y_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      mod_q   <= WIDTH'(DEFAULT_MOD);
      y_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      mod_q   <= mod_d;
      y_q     <= y_d;
    end
  end

  // Terminal count is high only in the cycle whose closing edge actually wraps.
  assign tc_o    = rst_ni & en_i & ~load_i & wrap;
  assign count_o = count_q;
  assign mod_o   = mod_q;
  assign y_o     = y_q;

endmodule : prog_modulo_counter
`default_nettype wire

// File: tb/tb_prog_modulo_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prog_modulo_counter                                       |
// | Description : Self-checking bench for prog_modulo_counter with a modular-  |
// |               arithmetic reference model and randomized stimulus.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prog_modulo_counter;

  localparam int W  = 4;
  localparam int DM = 6;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         en     = 1'b0;
  logic         load   = 1'b0;
  logic [W-1:0] mod_in = '0;
  logic         up_dn  = 1'b1;
  logic [W-1:0] count;
  logic [W-1:0] modv;
  logic         tc;
  logic         y;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: count, modulus and divided output as plain integers.
  int m_count = 0;
  int m_mod   = DM;
  int m_y     = 0;

  always #5 clk = ~clk;

  prog_modulo_counter #(
    .WIDTH       (W),
    .DEFAULT_MOD (DM)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .load_i   (load),
    .mod_in_i (mod_in),
`ifdef MODCNT_UPDOWN_EN
    .up_dn_i  (up_dn),
`endif
    .count_o  (count),
    .mod_o    (modv),
    .tc_o     (tc),
    .y_o      (y)
  );

  function automatic bit going_up();
`ifdef MODCNT_UPDOWN_EN
    return up_dn;
`else
    return 1'b1;
`endif
  endfunction

  // Expected terminal-count flag from the model's current state and the inputs.
  function automatic bit exp_tc();
    if (!rst_n || !en || load) return 1'b0;
    return going_up() ? (m_count == m_mod - 1) : (m_count == 0);
  endfunction

  // Advance one clock and apply the counter rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_count = 0; m_mod = DM; m_y = 0;
    end else if (load) begin
      m_mod   = (int'(mod_in) < 2) ? 2 : int'(mod_in);
      m_count = 0;
    end else if (en) begin
      if (going_up()) begin
        m_count = (m_count + 1) % m_mod;
        if (m_count == 0) m_y = 1 - m_y;
      end else begin
        if (m_count == 0) m_y = 1 - m_y;
        m_count = (m_count + m_mod - 1) % m_mod;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; up_dn = 1'b1; mod_in = '0;
    m_count = 0; m_mod = DM; m_y = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (count !== 4'd0 || modv !== 4'd6 || y !== 1'b0)
      $display("FAIL reset_state: count=%0d mod=%0d y=%0b required 0/6/0", count, modv, y);
    else n_pass++;
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (count !== 4'd3) $display("FAIL reset_precount: count=%0d required 3", count);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    m_count = 0; m_mod = DM; m_y = 0;
    n_checks++;
    if (count !== 4'd0 || modv !== 4'd6 || y !== 1'b0 || tc !== 1'b0)
      $display("FAIL reset_async: count=%0d mod=%0d y=%0b tc=%0b required 0/6/0/0", count, modv, y, tc);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_defaults();
    int tog[$];
    logic yp;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      #1;
      n_checks++;
      if (tc !== exp_tc()) $display("FAIL defaults_tc: cycle %0d tc=%0b required %0b", i, tc, exp_tc());
      else n_pass++;
      yp = y;
      tick();
      if (y !== yp) tog.push_back(i);
      n_checks++;
      if (count !== W'(m_count) || modv !== W'(m_mod) || y !== m_y[0])
        $display("FAIL defaults_state: cycle %0d count=%0d mod=%0d y=%0b required %0d/%0d/%0b",
                 i, count, modv, y, m_count, m_mod, m_y[0]);
      else n_pass++;
    end
    n_checks++;
    if (tog.size() != 4 || tog[0] != 6 || tog[1] != 12 || tog[2] != 18 || tog[3] != 24)
      $display("FAIL defaults_y_toggles: got %0d toggles %p required cycles 6,12,18,24", tog.size(), tog);
    else n_pass++;
  endtask

  task automatic test_enable_toggle();
    int ntog;
    logic yp;
    ntog = 0;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      en = (i % 2 == 0);
      #1;
      n_checks++;
      if (tc !== exp_tc()) $display("FAIL entoggle_tc: cycle %0d tc=%0b required %0b", i, tc, exp_tc());
      else n_pass++;
      yp = y;
      tick();
      if (y !== yp) ntog++;
      n_checks++;
      if (count !== W'(m_count) || y !== m_y[0])
        $display("FAIL entoggle_state: cycle %0d count=%0d y=%0b required %0d/%0b", i, count, y, m_count, m_y[0]);
      else n_pass++;
    end
    en = 1'b0;
    n_checks++;
    if (ntog != 4) $display("FAIL entoggle_y_toggles: got %0d required 4", ntog);
    else n_pass++;
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    load = 1'b1; mod_in = 4'd3;
    #1;
    n_checks++;
    if (tc !== 1'b0) $display("FAIL load_tc: tc=%0b required 0", tc);
    else n_pass++;
    tick();
    load = 1'b0;
    n_checks++;
    if (count !== 4'd0 || modv !== 4'd3 || y !== 1'b0)
      $display("FAIL load_state: count=%0d mod=%0d y=%0b required 0/3/0", count, modv, y);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (tc !== exp_tc()) $display("FAIL load_run_tc: step %0d tc=%0b required %0b", i, tc, exp_tc());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (count !== 4'd0 || y !== 1'b1)
      $display("FAIL load_wrap: count=%0d y=%0b required 0/1", count, y);
    else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_clamp();
    int ntog;
    logic yp;
    ntog = 0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      load = 1'b1; mod_in = W'(k);
      tick();
      load = 1'b0;
      n_checks++;
      if (modv !== 4'd2 || count !== 4'd0)
        $display("FAIL clamp_mod: mod_in=%0d mod=%0d count=%0d required 2/0", k, modv, count);
      else n_pass++;
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      yp = y;
      tick();
      if (y !== yp) ntog++;
      n_checks++;
      if (count !== W'(m_count)) $display("FAIL clamp_count: step %0d count=%0d required %0d", i, count, m_count);
      else n_pass++;
    end
    n_checks++;
    if (ntog != 4) $display("FAIL clamp_y_toggles: got %0d required 4", ntog);
    else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_load_at_tc();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    n_checks++;
    if (tc !== 1'b1) $display("FAIL tcload_pre: tc=%0b required 1", tc);
    else n_pass++;
    load = 1'b1; mod_in = 4'd9;
    #1;
    n_checks++;
    if (tc !== 1'b0) $display("FAIL tcload_tc: tc=%0b required 0", tc);
    else n_pass++;
    tick();
    load = 1'b0; en = 1'b0;
    n_checks++;
    if (count !== 4'd0 || modv !== 4'd9 || y !== 1'b0)
      $display("FAIL tcload_state: count=%0d mod=%0d y=%0b required 0/9/0", count, modv, y);
    else n_pass++;
  endtask

`ifdef MODCNT_UPDOWN_EN
  task automatic test_down();
    int seq[6] = '{5, 4, 3, 2, 1, 0};
    do_reset();
    up_dn = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++;
      if (tc !== exp_tc()) $display("FAIL down_tc: step %0d tc=%0b required %0b", i, tc, exp_tc());
      else n_pass++;
      tick();
      n_checks++;
      if (count !== W'(seq[i % 6]) || y !== m_y[0])
        $display("FAIL down_state: step %0d count=%0d y=%0b required %0d/%0b", i, count, y, seq[i % 6], m_y[0]);
      else n_pass++;
    end
    en = 1'b0; up_dn = 1'b1;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 3) != 0);
      load   = ($urandom_range(0, 19) == 0);
      mod_in = W'($urandom);
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      #1;
      n_checks++;
      if (tc !== exp_tc()) $display("FAIL random_tc: cycle %0d tc=%0b required %0b", i, tc, exp_tc());
      else n_pass++;
      tick();
      n_checks++;
      if (count !== W'(m_count) || modv !== W'(m_mod) || y !== m_y[0])
        $display("FAIL random_state: cycle %0d count=%0d mod=%0d y=%0b required %0d/%0d/%0b",
                 i, count, modv, y, m_count, m_mod, m_y[0]);
      else n_pass++;
    end
    en = 1'b0; load = 1'b0; up_dn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_enable_toggle();
    test_load();
    test_clamp();
    test_load_at_tc();
`ifdef MODCNT_UPDOWN_EN
    test_down();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule : tb_prog_modulo_counter
`default_nettype wire

// File: doc/prog_modulo_counter.md
# prog_modulo_counter

Parametrised, run-time-programmable modulo-N counter and clock-enable divider, generalising the fixed divide-by-6 counter and toggle output used in the lab timing chain. Counts 0..N-1 under an enable, wraps, flags the terminal count, and toggles a divided output on every wrap. The modulus is loadable at run time. An optional compile-time up/down mode is available. Sits between the system clock and any downstream block that needs a slow enable or a square-wave tick.

## Interface
- WIDTH, 4: counter and modulus width in bits; legal range 2..16.
- DEFAULT_MOD, 6: modulus after reset; legal range 2..2^WIDTH-1.

- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset; one clock.
- En  input  1  count enable; counter advances only when high.
- Load  input  1  synchronous modulus load strobe.
- Mod_in  input  WIDTH  modulus value sampled when Load=1.
- Up_dn  input  1  direction, 1=up, 0=down; present only with MODCNT_UPDOWN_EN.
- Count  output  WIDTH  current count, always in 0..Mod-1.
- Mod  output  WIDTH  current active modulus.
- Tc  output  1  terminal-count flag, combinational.
- Y  output  1  divided output; toggles on every wrap.

## Operation
- Registers: count_r (WIDTH), mod_r (WIDTH), y_r (1). Count=count_r, Mod=mod_r, Y=y_r.
- Reset low, asynchronous: count_r=0, mod_r=DEFAULT_MOD, y_r=0. Tc=0 while Reset is low.
- Priority per edge: Reset > Load > En.
- Load=1:
  - mod_r ← Mod_in if Mod_in ≥ 2; otherwise mod_r ← 2 (clamp).
  - count_r ← 0; y_r unchanged; En ignored that cycle; no wrap and no toggle.
- En=1, up direction:
  - count_r==mod_r-1 → count_r←0 and y_r toggles.
  - Otherwise count_r←count_r+1.
- En=1, down direction:
  - count_r==0 → count_r←mod_r-1 and y_r toggles.
  - Otherwise count_r←count_r-1.
- En=0: all state holds.
- Tc = Reset & En & ~Load & (up ? count_r==mod_r-1 : count_r==0). Tc is high exactly in the cycle whose closing edge wraps the counter.
- Arithmetic is WIDTH bits and unsigned. Compare against mod_r-1 with no overflow: mod_r ≥ 2 always holds.
- Direction change mid-count takes effect on the next enabled edge from the current value. No reset of count_r.
- Load during the terminal cycle: the load wins, and no toggle occurs.

## Timing
- Count, Mod, and Y are registered; changes are visible one Clk after the causing edge.
- Tc is combinational from registers plus En/Load; same-cycle.
- With En held high and a constant modulus N: Count period = N cycles; Tc is high 1 of every N cycles; Y period = 2N cycles, 50% duty.
- Load → new Mod is visible next cycle. The first wrap occurs N enabled cycles after the load.
- Reset deassertion is not synchronised internally. The integrating top drives it synchronously released.

## Configuration
- MODCNT_UPDOWN_EN defined: the Up_dn port exists and down counting is as above.
- Not defined: the Up_dn port is absent; the block counts up only and the direction logic is removed.

## Structure
- Shared package modcnt_pkg:
  - MODCNT_MIN_MOD=2 constant.
  - dir_e typedef (DIR_DN=0, DIR_UP=1).
  - Width-check constant function, used by an elaboration-time assertion on WIDTH/DEFAULT_MOD.
- One sub-module, modcnt_next: a combinational next-count/wrap generator with inputs count, mod, dir, and outputs next, wrap. The top holds the registers, load/clamp logic, and y_r toggle.

## Test plan
- Reset low mid-count (Count=3) → Count=0, Mod=6, Y=0 immediately, without waiting for a Clk edge.
- Defaults, En=1 for 24 cycles → Count 0,1,2,3,4,5,0…; Tc high when Count=5; Y toggles at cycles 6, 12, 18, 24 (period 12).
- En toggled 1/0 every cycle → Count advances only on enabled edges; Y period 24 cycles.
- Count=4, Load=1, Mod_in=3 → next Count=0, Mod=3; then 0,1,2,0 with Tc at 2; Y not toggled by the load.
- Load with Mod_in=0, then Mod_in=1 → Mod=2 both times; Count alternates 0,1; Y period 4.
- With MODCNT_UPDOWN_EN: Up_dn=0, Mod=6 from reset → Count 0,5,4,3,2,1,0; Tc high at Count=0; Y toggles on each 0→5 transition.
